// File: rtl/ps2_key_entry_ctrl.sv
// PS/2 scancode filter and hex-block assembler feeding the AES core.
// Make/break/extended sequences are filtered; accepted digits shift in at the LSB end.
module ps2_key_entry_ctrl #(
  parameter int unsigned NIBBLES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           scan_valid,
  input  logic [7:0]                     scan_code,
  output logic [7:0]                     xlat_code,
  input  logic [7:0]                     xlat_ascii,
  output logic                           echo_valid,
  output logic [7:0]                     echo_ascii,
  output logic [$clog2(NIBBLES+1)-1:0]   count,
  output logic [4*NIBBLES-1:0]           block_data,
  output logic                           block_valid,
  input  logic                           block_ready
);

  localparam int unsigned CW = $clog2(NIBBLES + 1);
  localparam int unsigned BW = 4 * NIBBLES;
  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  localparam logic [2:0] S_COLLECT   = 3'd0;
  localparam logic [2:0] S_BREAK     = 3'd1;
  localparam logic [2:0] S_EXT       = 3'd2;
  localparam logic [2:0] S_EXT_BREAK = 3'd3;
  localparam logic [2:0] S_XLAT      = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;

  localparam logic [7:0] K_BREAK = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_ESC   = 8'h76;

  logic [2:0]    state_q, state_d;
  logic [7:0]    xlat_code_q, xlat_code_d;
  logic [7:0]    echo_ascii_q, echo_ascii_d;
  logic          echo_valid_q, echo_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] block_q, block_d;

  logic       is_hex;
  logic [7:0] nib_wide;

  // Validity comes only from the make code, never from the translator output.
  always_comb begin
    case (scan_code)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B: is_hex = 1'b1;
      default:                                  is_hex = 1'b0;
    endcase
  end

  always_comb begin
    if (xlat_ascii >= 8'h41) nib_wide = xlat_ascii - 8'h37;
    else                     nib_wide = xlat_ascii - 8'h30;
  end

  always_comb begin
    state_d      = state_q;
    xlat_code_d  = xlat_code_q;
    echo_ascii_d = echo_ascii_q;
    echo_valid_d = 1'b0;
    count_d      = count_q;
    block_d      = block_q;
    case (state_q)
      S_COLLECT: begin
        if (scan_valid) begin
          if (scan_code == K_BREAK) begin
            state_d = S_BREAK;
          end else if (scan_code == K_EXT) begin
            state_d = S_EXT;
          end else if (is_hex && (count_q < FULL)) begin
            xlat_code_d = scan_code;
            state_d     = S_XLAT;
          end else if ((scan_code == K_BKSP) && (count_q != '0)) begin
            block_d = block_q >> 4;
            count_d = count_q - 1'b1;
          end else if (scan_code == K_ESC) begin
            block_d = '0;
            count_d = '0;
          end else if ((scan_code == K_ENTER) && (count_q == FULL)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_BREAK, S_EXT_BREAK: begin
        if (scan_valid) state_d = S_COLLECT;
      end
      S_EXT: begin
        if (scan_valid) state_d = (scan_code == K_BREAK) ? S_EXT_BREAK : S_COLLECT;
      end
      S_XLAT: begin
        block_d      = {block_q[BW-5:0], nib_wide[3:0]};
        count_d      = count_q + 1'b1;
        echo_valid_d = 1'b1;
        echo_ascii_d = xlat_ascii;
        state_d      = S_COLLECT;
      end
      S_HOLD: begin
        if (block_ready) begin
          block_d = '0;
          count_d = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      xlat_code_q  <= '0;
      echo_ascii_q <= '0;
      echo_valid_q <= 1'b0;
      count_q      <= '0;
      block_q      <= '0;
    end else begin
      state_q      <= state_d;
      xlat_code_q  <= xlat_code_d;
      echo_ascii_q <= echo_ascii_d;
      echo_valid_q <= echo_valid_d;
      count_q      <= count_d;
      block_q      <= block_d;
    end
  end

  assign xlat_code   = xlat_code_q;
  assign echo_ascii  = echo_ascii_q;
  assign echo_valid  = echo_valid_q;
  assign count       = count_q;
  assign block_data  = block_q;
  assign block_valid = (state_q == S_HOLD);

endmodule

// File: tb/tb_ps2_key_entry_ctrl.sv
// Directed bench for ps2_key_entry_ctrl with a behavioural scancode-to-ASCII translator.
module tb_ps2_key_entry_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_valid = 1'b0;
  logic [7:0]   scan_code = '0;
  logic [7:0]   xlat_code;
  logic [7:0]   xlat_ascii;
  logic         echo_valid;
  logic [7:0]   echo_ascii;
  logic [5:0]   count;
  logic [127:0] block_data;
  logic         block_valid;
  logic         block_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int echo_cnt = 0;

  logic [7:0] hexc [0:15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  ps2_key_entry_ctrl #(.NIBBLES(32)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .xlat_code(xlat_code), .xlat_ascii(xlat_ascii), .echo_valid(echo_valid),
    .echo_ascii(echo_ascii), .count(count), .block_data(block_data),
    .block_valid(block_valid), .block_ready(block_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    xlat_ascii = 8'h00;
    for (int i = 0; i < 16; i++)
      if (xlat_code == hexc[i]) xlat_ascii = (i < 10) ? 8'(8'h30 + i) : 8'(8'h37 + i);
  end

  always @(posedge clk) if (echo_valid) echo_cnt <= echo_cnt + 1;

  task automatic do_reset();
    rst = 1'b1; scan_valid = 1'b0; block_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    scan_code = c; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, inout logic [127:0] exp);
    for (int i = 0; i < n; i++) begin
      send(hexc[i % 16]);
      exp = {exp[123:0], 4'(i % 16)};
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({xlat_code, echo_ascii, echo_valid, count, block_data, block_valid} !== '0) begin
      errors++;
      $display("FAIL reset: xlat=%h echo=%h/%b count=%0d block=%h valid=%b, required all zero",
               xlat_code, echo_ascii, echo_valid, count, block_data, block_valid);
    end
  endtask

  task automatic test_digit_timing();
    int base;
    do_reset();
    base = echo_cnt;
    scan_code = 8'h16; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    checks++;
    if (xlat_code !== 8'h16 || echo_valid !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL digit_t1: xlat=%h echo_valid=%b count=%0d, required 16/0/0", xlat_code, echo_valid, count);
    end
    @(posedge clk); #1;
    checks++;
    if (echo_valid !== 1'b1 || echo_ascii !== 8'h31 || count !== 6'd1 || block_data !== 128'h1) begin
      errors++;
      $display("FAIL digit_t2: echo=%b/%h count=%0d block=%h, required 1/31/1/1", echo_valid, echo_ascii, count, block_data);
    end
    @(posedge clk); #1;
    checks++;
    if (echo_valid !== 1'b0) begin
      errors++;
      $display("FAIL digit_pulse: echo_valid=%b, required 0", echo_valid);
    end
    send(8'hF0); send(8'h16);
    checks++;
    if (echo_cnt - base !== 1 || count !== 6'd1 || block_data !== 128'h1 || xlat_code !== 8'h16) begin
      errors++;
      $display("FAIL break_seq: echoes=%0d count=%0d block=%h xlat=%h, required 1/1/1/16",
               echo_cnt - base, count, block_data, xlat_code);
    end
  endtask

  task automatic test_full_block();
    logic [127:0] exp = '0;
    int hi = 0;
    do_reset();
    fill(32, exp);
    checks++;
    if (count !== 6'd32 || block_data !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      errors++;
      $display("FAIL full_fill: count=%0d block=%h, required 32/0123456789ABCDEF0123456789ABCDEF", count, block_data);
    end
    scan_code = 8'h5A; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!block_valid) break;
      hi++;
      checks++;
      if (block_data !== exp) begin
        errors++;
        $display("FAIL hold_data: block=%h, required %h", block_data, exp);
      end
      block_ready = (hi >= 4);
      @(posedge clk); #1;
    end
    block_ready = 1'b0;
    checks++;
    if (hi !== 4 || count !== 6'd0 || block_data !== '0 || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake: valid_cycles=%0d count=%0d block=%h valid=%b, required 4/0/0/0",
               hi, count, block_data, block_valid);
    end
  endtask

  task automatic test_backspace();
    logic [127:0] exp = '0;
    do_reset();
    send(8'h1C); send(8'h2E); send(8'h66); send(8'h21);
    checks++;
    if (block_data !== 128'hAC || count !== 6'd2) begin
      errors++;
      $display("FAIL backspace: block=%h count=%0d, required AC/2", block_data, count);
    end
    send(8'h76); send(8'h66);
    checks++;
    if (block_data !== '0 || count !== 6'd0) begin
      errors++;
      $display("FAIL bksp_zero: block=%h count=%0d, required 0/0", block_data, count);
    end
    fill(5, exp);
    send(8'h5A);
    checks++;
    if (block_valid !== 1'b0 || count !== 6'd5 || block_data !== exp) begin
      errors++;
      $display("FAIL enter_partial: valid=%b count=%0d block=%h, required 0/5/%h", block_valid, count, block_data, exp);
    end
  endtask

  task automatic test_ignored();
    logic [127:0] exp = '0;
    int base;
    do_reset();
    send(8'h16); send(8'h1E);
    base = echo_cnt;
    send(8'h34);
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    checks++;
    if (echo_cnt !== base || count !== 6'd2 || block_data !== 128'h12 || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_codes: echoes=%0d count=%0d block=%h valid=%b, required 0/2/12/0",
               echo_cnt - base, count, block_data, block_valid);
    end
    do_reset();
    fill(32, exp);
    base = echo_cnt;
    send(8'h1C);
    send(8'hE0); send(8'h5A);
    checks++;
    if (echo_cnt !== base || count !== 6'd32 || block_data !== exp || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_full: echoes=%0d count=%0d block=%h valid=%b, required 0/32/%h/0",
               echo_cnt - base, count, block_data, block_valid, exp);
    end
  endtask

  task automatic test_escape_hold();
    logic [127:0] exp = '0;
    int base;
    do_reset();
    fill(7, exp);
    scan_code = 8'h76; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    checks++;
    if (count !== 6'd0 || block_data !== '0) begin
      errors++;
      $display("FAIL escape: count=%0d block=%h, required 0/0", count, block_data);
    end
    exp = '0;
    fill(32, exp);
    send(8'h5A);
    base = echo_cnt;
    send(8'h16); send(8'h66); send(8'h76);
    checks++;
    if (block_valid !== 1'b1 || count !== 6'd32 || block_data !== exp || echo_cnt !== base) begin
      errors++;
      $display("FAIL hold_ignore: valid=%b count=%0d block=%h echoes=%0d, required 1/32/%h/0",
               block_valid, count, block_data, echo_cnt - base, exp);
    end
    block_ready = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b0;
    checks++;
    if (block_valid !== 1'b0 || count !== 6'd0 || block_data !== '0) begin
      errors++;
      $display("FAIL hold_release: valid=%b count=%0d block=%h, required 0/0/0", block_valid, count, block_data);
    end
  endtask

  task automatic test_reset_in_hold();
    logic [127:0] exp = '0;
    do_reset();
    fill(32, exp);
    send(8'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (block_valid !== 1'b0 || count !== 6'd0 || block_data !== '0 || xlat_code !== 8'h00) begin
      errors++;
      $display("FAIL rst_hold: valid=%b count=%0d block=%h xlat=%h, required 0/0/0/00",
               block_valid, count, block_data, xlat_code);
    end
    send(8'h46);
    checks++;
    if (count !== 6'd1 || block_data !== 128'h9 || echo_ascii !== 8'h39) begin
      errors++;
      $display("FAIL post_rst_digit: count=%0d block=%h echo=%h, required 1/9/39", count, block_data, echo_ascii);
    end
  endtask

  initial begin
    test_reset();
    test_digit_timing();
    test_full_block();
    test_backspace();
    test_ignored();
    test_escape_hold();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
